// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//   Per-frame controller for a double-buffered framebuffer. Each frame runs
//   clear back buffer -> render -> request swap -> wait for the displayed side
//   to flip -> next frame. A watchdog re-issues the swap request if the swap
//   unit does not flip the displayed side in time.
//
// Ports
//   CLK        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enable     in   level, run the frame loop while high
//   side       in   displayed buffer from the swap unit (back = ~side)
//   frame_done in   1-cycle pulse from the renderer, back buffer complete
//   clr_done   in   1-cycle pulse from the clear engine
//   swap_req   out  1-cycle pulse to the swap unit
//   clr_start  out  1-cycle pulse to the clear engine
//   render_go  out  level, renderer may draw while high
//   back_sel   out  buffer targeted by renderer and clear engine
//   frame_cnt  out  completed (swapped) frames, wraps
//   busy       out  high in every state except IDLE
//   swap_tmo   out  sticky swap watchdog error
//   state_dbg  out  current FSM state encoding, for debug and checkers
//
// Handshake: every request/acknowledge here is a single-cycle pulse with no
// back-pressure. clr_start and swap_req are asserted for exactly one cycle;
// clr_done is only looked at in CLEAR_WT and frame_done only in RENDER, so a
// pulse that arrives in any other state is dropped.
// -----------------------------------------------------------------------------
module frame_sequencer #(
   parameter bit                CLEAR_EN = 1'b1,
   parameter int unsigned       TMO_W    = 24,
   parameter logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(2_000_000),
   parameter int unsigned       FCNT_W   = 16
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              side,
   input  logic              frame_done,
   input  logic              clr_done,
   output logic              swap_req,
   output logic              clr_start,
   output logic              render_go,
   output logic              back_sel,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              busy,
   output logic              swap_tmo,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CLEAR_ST  = 3'd1,
      CLEAR_WT  = 3'd2,
      RENDER    = 3'd3,
      SWAP      = 3'd4,
      WAIT_SWAP = 3'd5
   } state_t;

   // Last watchdog value that is still inside the allowed wait window.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - TMO_W'(1);

   state_t           state;
   logic             side_q;
   logic [TMO_W-1:0] wd;

   assign state_dbg = state;

   // Output timing: swap_req and render_go are set on the edge that enters
   // SWAP / RENDER, so they follow frame_done / clr_done by one cycle.
   // clr_start is set on the edge that leaves CLEAR_ST, which puts it in the
   // third cycle counting the cycle the side flip appears in.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         swap_req  <= 1'b0;
         clr_start <= 1'b0;
         render_go <= 1'b0;
         busy      <= 1'b0;
         swap_tmo  <= 1'b0;
         frame_cnt <= '0;
         side_q    <= 1'b1;   // keeps back_sel = ~side_q = 0 while in reset
         back_sel  <= 1'b0;
         wd        <= '0;
      end else begin
         swap_req  <= 1'b0;
         clr_start <= 1'b0;
         case (state)
            IDLE: begin
               // Track the displayed side while parked so the first frame
               // targets the correct back buffer.
               side_q   <= side;
               back_sel <= ~side;
               if (enable) begin
                  busy <= 1'b1;
                  if (CLEAR_EN) begin
                     state <= CLEAR_ST;
                  end else begin
                     state     <= RENDER;
                     render_go <= 1'b1;
                  end
               end
            end
            CLEAR_ST: begin
               clr_start <= 1'b1;
               back_sel  <= ~side_q;
               state     <= CLEAR_WT;
            end
            CLEAR_WT: begin
               if (clr_done) begin
                  if (enable) begin
                     state     <= RENDER;
                     render_go <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            RENDER: begin
               // enable is not looked at here: a started frame always swaps.
               if (frame_done) begin
                  state     <= SWAP;
                  render_go <= 1'b0;
                  swap_req  <= 1'b1;
               end
            end
            SWAP: begin
               side_q <= side;
               wd     <= '0;
               state  <= WAIT_SWAP;
            end
            WAIT_SWAP: begin
               // A flip takes priority over a watchdog expiry in the same cycle.
               if (side != side_q) begin
                  frame_cnt <= frame_cnt + FCNT_W'(1);
                  side_q    <= side;
                  if (CLEAR_EN) begin
                     state <= CLEAR_ST;
                  end else if (enable) begin
                     state     <= RENDER;
                     render_go <= 1'b1;
                     back_sel  <= ~side;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else if (wd >= TMO_LAST) begin
                  swap_tmo <= 1'b1;
                  swap_req <= 1'b1;
                  state    <= SWAP;
               end else if (wd != '1) begin
                  wd <= wd + TMO_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
//   Directed bench for frame_sequencer with CLEAR_EN = 1, TMO_MAX = 100 and
//   FCNT_W = 4. Inputs are driven 1 time unit after a rising edge and outputs
//   are sampled at the same point, so every sample reflects the last edge.
// -----------------------------------------------------------------------------
module tb_frame_sequencer;

   localparam int FCNT_W = 4;

   logic              CLK;
   logic              rst_n;
   logic              enable;
   logic              side;
   logic              frame_done;
   logic              clr_done;
   logic              swap_req;
   logic              clr_start;
   logic              render_go;
   logic              back_sel;
   logic [FCNT_W-1:0] frame_cnt;
   logic              busy;
   logic              swap_tmo;
   logic [2:0]        state_dbg;

   int n_cmp = 0;
   int n_bad = 0;

   frame_sequencer #(
      .CLEAR_EN (1'b1),
      .TMO_W    (24),
      .TMO_MAX  (24'd100),
      .FCNT_W   (FCNT_W)
   ) dut (
      .CLK        (CLK),
      .rst_n      (rst_n),
      .enable     (enable),
      .side       (side),
      .frame_done (frame_done),
      .clr_done   (clr_done),
      .swap_req   (swap_req),
      .clr_start  (clr_start),
      .render_go  (render_go),
      .back_sel   (back_sel),
      .frame_cnt  (frame_cnt),
      .busy       (busy),
      .swap_tmo   (swap_tmo),
      .state_dbg  (state_dbg)
   );

   // ---------------- clock ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; side = 1'b0; frame_done = 1'b0; clr_done = 1'b0;
      #12;
      n_cmp++;
      if ({swap_req, clr_start, render_go, back_sel, busy, swap_tmo, frame_cnt} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b want all zero",
                  {swap_req, clr_start, render_go, back_sel, busy, swap_tmo, frame_cnt});
      end
      tick();
      rst_n = 1'b1;
      tick();
      // side = 0 captured while idle -> back buffer is 1
      n_cmp++;
      if (back_sel !== 1'b1) begin n_bad++; $display("FAIL reset_back_sel: got %b want 1", back_sel); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_first_frame();
      enable = 1'b1;
      tick();  // IDLE -> CLEAR_ST
      n_cmp++;
      if (busy !== 1'b1 || clr_start !== 1'b0) begin
         n_bad++; $display("FAIL start_busy: got busy=%b clr_start=%b want 1 0", busy, clr_start);
      end
      tick();  // CLEAR_ST -> CLEAR_WT, clr_start pulse
      n_cmp++;
      if (clr_start !== 1'b1 || back_sel !== 1'b1) begin
         n_bad++; $display("FAIL first_clr_start: got clr_start=%b back_sel=%b want 1 1", clr_start, back_sel);
      end
      tick();
      n_cmp++;
      if (clr_start !== 1'b0) begin n_bad++; $display("FAIL clr_start_width: got %b want 0", clr_start); end
      tick();
      clr_done = 1'b1;
      tick();
      clr_done = 1'b0;
      n_cmp++;
      if (render_go !== 1'b1) begin n_bad++; $display("FAIL clr_done_to_render: got %b want 1", render_go); end
   endtask

   task automatic test_swap();
      tick(); tick(); tick();
      n_cmp++;
      if (render_go !== 1'b1 || swap_req !== 1'b0) begin
         n_bad++; $display("FAIL render_hold: got render_go=%b swap_req=%b want 1 0", render_go, swap_req);
      end
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      n_cmp++;
      if (swap_req !== 1'b1 || render_go !== 1'b0) begin
         n_bad++; $display("FAIL frame_done_to_swap: got swap_req=%b render_go=%b want 1 0", swap_req, render_go);
      end
      tick();
      n_cmp++;
      if (swap_req !== 1'b0) begin n_bad++; $display("FAIL swap_req_width: got %b want 0", swap_req); end
      for (int i = 0; i < 8; i++) tick();
      n_cmp++;
      if (frame_cnt !== 4'd0 || busy !== 1'b1) begin
         n_bad++; $display("FAIL wait_no_count: got cnt=%0d busy=%b want 0 1", frame_cnt, busy);
      end
      side = 1'b1;
      tick();  // flip detected
      n_cmp++;
      if (frame_cnt !== 4'd1 || clr_start !== 1'b0) begin
         n_bad++; $display("FAIL flip_count: got cnt=%0d clr_start=%b want 1 0", frame_cnt, clr_start);
      end
      tick();  // clr_start in third cycle counting the flip cycle
      n_cmp++;
      if (clr_start !== 1'b1 || back_sel !== 1'b0) begin
         n_bad++; $display("FAIL flip_to_clr_start: got clr_start=%b back_sel=%b want 1 0", clr_start, back_sel);
      end
      tick();
      n_cmp++;
      if (clr_start !== 1'b0) begin n_bad++; $display("FAIL clr_start_width2: got %b want 0", clr_start); end
   endtask

   task automatic test_spurious();
      // In CLEAR_WT: frame_done and a side toggle must be ignored.
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      n_cmp++;
      if (swap_req !== 1'b0 || render_go !== 1'b0) begin
         n_bad++; $display("FAIL spurious_frame_done: got swap_req=%b render_go=%b want 0 0", swap_req, render_go);
      end
      side = 1'b0;
      tick();
      n_cmp++;
      if (frame_cnt !== 4'd1 || back_sel !== 1'b0) begin
         n_bad++; $display("FAIL spurious_side: got cnt=%0d back_sel=%b want 1 0", frame_cnt, back_sel);
      end
      clr_done = 1'b1;
      tick();
      clr_done = 1'b0;
      // In RENDER: a stray clr_done must not disturb anything.
      clr_done = 1'b1;
      tick();
      clr_done = 1'b0;
      n_cmp++;
      if (render_go !== 1'b1 || clr_start !== 1'b0 || swap_req !== 1'b0) begin
         n_bad++; $display("FAIL spurious_clr_done: got render_go=%b clr_start=%b swap_req=%b want 1 0 0",
                           render_go, clr_start, swap_req);
      end
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      n_cmp++;
      if (swap_req !== 1'b1) begin n_bad++; $display("FAIL tmo_first_swap: got %b want 1", swap_req); end
      // One SWAP cycle then 99 WAIT_SWAP cycles: nothing may fire yet.
      for (int i = 0; i < 100; i++) begin
         tick();
         if (swap_tmo !== 1'b0 || swap_req !== 1'b0) early++;
      end
      n_cmp++;
      if (early !== 0) begin n_bad++; $display("FAIL tmo_early: got %0d early cycles want 0", early); end
      tick();  // cycle 100 of WAIT_SWAP
      n_cmp++;
      if (swap_tmo !== 1'b1 || swap_req !== 1'b1) begin
         n_bad++; $display("FAIL tmo_expiry: got swap_tmo=%b swap_req=%b want 1 1", swap_tmo, swap_req);
      end
      tick();
      n_cmp++;
      if (swap_req !== 1'b0 || frame_cnt !== 4'd1) begin
         n_bad++; $display("FAIL tmo_reissue: got swap_req=%b cnt=%0d want 0 1", swap_req, frame_cnt);
      end
      frame_done = 1'b1;  // stray pulse in WAIT_SWAP
      tick();
      frame_done = 1'b0;
      n_cmp++;
      if (swap_req !== 1'b0) begin n_bad++; $display("FAIL wait_frame_done: got %b want 0", swap_req); end
      side = 1'b1;
      tick();
      n_cmp++;
      if (frame_cnt !== 4'd2) begin n_bad++; $display("FAIL tmo_flip_count: got %0d want 2", frame_cnt); end
      tick();
      n_cmp++;
      if (clr_start !== 1'b1 || back_sel !== 1'b0) begin
         n_bad++; $display("FAIL tmo_clr_start: got clr_start=%b back_sel=%b want 1 0", clr_start, back_sel);
      end
      tick(); tick();
      n_cmp++;
      if (frame_cnt !== 4'd2 || swap_tmo !== 1'b1) begin
         n_bad++; $display("FAIL tmo_sticky: got cnt=%0d swap_tmo=%b want 2 1", frame_cnt, swap_tmo);
      end
   endtask

   task automatic test_enable_drop();
      clr_done = 1'b1;
      tick();
      clr_done = 1'b0;
      enable = 1'b0;
      tick(); tick(); tick();
      n_cmp++;
      if (render_go !== 1'b1 || busy !== 1'b1) begin
         n_bad++; $display("FAIL drop_render_holds: got render_go=%b busy=%b want 1 1", render_go, busy);
      end
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      n_cmp++;
      if (swap_req !== 1'b1) begin n_bad++; $display("FAIL drop_swap_req: got %b want 1", swap_req); end
      tick();
      side = 1'b0;
      tick();
      n_cmp++;
      if (frame_cnt !== 4'd3 || busy !== 1'b1) begin
         n_bad++; $display("FAIL drop_flip: got cnt=%0d busy=%b want 3 1", frame_cnt, busy);
      end
      tick();
      n_cmp++;
      if (clr_start !== 1'b1 || back_sel !== 1'b1) begin
         n_bad++; $display("FAIL drop_clear_runs: got clr_start=%b back_sel=%b want 1 1", clr_start, back_sel);
      end
      clr_done = 1'b1;
      tick();
      clr_done = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || render_go !== 1'b0) begin
         n_bad++; $display("FAIL drop_idle: got busy=%b render_go=%b want 0 0", busy, render_go);
      end
      tick(); tick();
      n_cmp++;
      if (busy !== 1'b0 || clr_start !== 1'b0) begin
         n_bad++; $display("FAIL drop_stays_idle: got busy=%b clr_start=%b want 0 0", busy, clr_start);
      end
   endtask

   task automatic test_wrap();
      logic [FCNT_W-1:0] exp_cnt;
      exp_cnt = 4'd3;
      enable  = 1'b1;
      tick();  // CLEAR_ST
      tick();  // CLEAR_WT with clr_start
      for (int i = 0; i < 14; i++) begin
         clr_done = 1'b1;   tick(); clr_done = 1'b0;    // RENDER
         frame_done = 1'b1; tick(); frame_done = 1'b0;  // SWAP
         tick();                                        // WAIT_SWAP
         side = ~side;      tick();                     // flip detected
         tick();                                        // CLEAR_WT, clr_start
         exp_cnt = exp_cnt + 4'd1;
         n_cmp++;
         if (frame_cnt !== exp_cnt || clr_start !== 1'b1) begin
            n_bad++; $display("FAIL wrap_frame_%0d: got cnt=%0d clr_start=%b want %0d 1",
                              i, frame_cnt, clr_start, exp_cnt);
         end
      end
      n_cmp++;
      if (frame_cnt !== 4'd1) begin n_bad++; $display("FAIL wrap_final: got %0d want 1", frame_cnt); end
   endtask

   task automatic test_async_reset();
      clr_done = 1'b1;   tick(); clr_done = 1'b0;
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      tick();  // WAIT_SWAP
      #3;
      rst_n  = 1'b0;
      enable = 1'b0;
      side   = 1'b1;
      #1;
      n_cmp++;
      if ({swap_req, clr_start, render_go, back_sel, busy, swap_tmo, frame_cnt} !== '0) begin
         n_bad++;
         $display("FAIL async_reset: got %b want all zero",
                  {swap_req, clr_start, render_go, back_sel, busy, swap_tmo, frame_cnt});
      end
      #2;
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (back_sel !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL post_reset_side1: got back_sel=%b busy=%b want 0 0", back_sel, busy);
      end
      enable = 1'b1;
      tick(); tick();
      n_cmp++;
      if (clr_start !== 1'b1 || back_sel !== 1'b0 || frame_cnt !== 4'd0) begin
         n_bad++; $display("FAIL post_reset_frame: got clr_start=%b back_sel=%b cnt=%0d want 1 0 0",
                           clr_start, back_sel, frame_cnt);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_first_frame();
      test_swap();
      test_spurious();
      test_timeout();
      test_enable_drop();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Per-frame controller for the double-buffered framebuffer.
- Sequences each frame: clear back buffer -> render -> request swap -> wait for the displayed side to flip -> next frame.
- Drives the swap_req input of the vsync-aligned swap unit and observes its side output.
- Gates the renderer (render_go / frame_done) and the clear engine (clr_start / clr_done).

Parameters:
- CLEAR_EN, 1, 1 = clear the back buffer before each frame; 0 = skip the CLEAR state.
- TMO_W, 24, width of the swap-wait watchdog counter.
- TMO_MAX, 24'd2_000_000, cycles allowed in WAIT_SWAP before timeout.
- FCNT_W, 16, frame counter width.

Ports:
- CLK  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; run frame loop while high.
- side  in  1  displayed buffer from the swap unit (front = side, back = ~side).
- frame_done  in  1  one-cycle pulse from renderer: back buffer complete.
- clr_done  in  1  one-cycle pulse from clear engine.
- swap_req  out  1  one-cycle pulse to the swap unit.
- clr_start  out  1  one-cycle pulse to the clear engine.
- render_go  out  1  level; renderer may draw while high.
- back_sel  out  1  buffer the renderer and clear engine target.
- frame_cnt  out  FCNT_W  completed (swapped) frames, wraps.
- busy  out  1  high in any state except IDLE.
- swap_tmo  out  1  sticky watchdog error flag.

Behaviour:
- Reset (async assert, synchronous release): state = IDLE; swap_req, clr_start, render_go, busy, swap_tmo = 0; frame_cnt = 0; side_q = side captured on the first clock after release; back_sel = ~side_q.
- back_sel is registered from side_q and updated only on entry to CLEAR/RENDER, so it never changes mid-frame.
- States:
  - IDLE: when enable = 1 -> CLEAR_ST (or RENDER if CLEAR_EN = 0).
  - CLEAR_ST: one cycle; clr_start = 1; back_sel = ~side_q -> CLEAR_WT.
  - CLEAR_WT: wait for clr_done.
    - clr_done and enable = 1 -> RENDER.
    - clr_done and enable = 0 -> IDLE.
  - RENDER: render_go = 1; on frame_done -> SWAP.
  - SWAP: one cycle; swap_req = 1; latch side_q = side; clear watchdog -> WAIT_SWAP.
  - WAIT_SWAP: render_go = 0.
    - side != side_q: frame_cnt += 1 (mod 2^FCNT_W); side_q = side; -> CLEAR_ST (or RENDER if CLEAR_EN = 0, with the same enable check as CLEAR_WT).
    - Watchdog reaches TMO_MAX first: swap_tmo = 1 (sticky until reset); -> SWAP (re-issue request); frame_cnt unchanged.
- Latencies:
  - frame_done to swap_req: exactly 1 cycle.
  - Side flip to clr_start: 3 cycles (detect, CLEAR_ST register, output).
  - clr_done to render_go high: 1 cycle.
  - A design with no added pipeline stages meets these; verification checks them exactly.
- Pulses (swap_req, clr_start) are exactly 1 cycle wide; never asserted in the same cycle.
- Inputs ignored outside their state:
  - frame_done outside RENDER.
  - clr_done outside CLEAR_WT.
- side toggling outside WAIT_SWAP does not count a frame; it updates side_q only while IDLE.
- enable deassertion:
  - Honoured only at IDLE or at CLEAR_WT / WAIT_SWAP exits.
  - RENDER and WAIT_SWAP always run to completion, so the displayed buffer is never left torn.
- Simultaneous events:
  - frame_done in the same cycle RENDER is entered counts.
  - Side flip and watchdog expiry in the same cycle: the flip wins, no timeout.
- Watchdog saturates; it does not wrap.
- frame_cnt wraps from all-ones to 0.
- Reset asserted mid-frame forces IDLE immediately; outputs take reset values asynchronously.

Test Plan:
- Reset, enable = 1 with side = 0 -> clr_start pulse with back_sel = 1; clr_done -> render_go = 1 one cycle later.
- In RENDER, pulse frame_done -> swap_req high exactly the next cycle for 1 cycle; toggle side 10 cycles later -> frame_cnt = 1, clr_start 3 cycles after the toggle, back_sel = 0.
- TMO_MAX = 100, never toggle side -> swap_tmo = 1 at cycle 100 of WAIT_SWAP, a second swap_req follows; later toggle -> frame_cnt increments once only.
- Drop enable during RENDER -> frame completes through swap and clear, then IDLE with busy = 0 and render_go = 0.
- FCNT_W = 4, run 17 frames -> frame_cnt = 1 after wrap; spurious frame_done/clr_done in wrong states -> no state change.
- Assert rst_n low mid WAIT_SWAP (async, between edges) -> all outputs 0 immediately; after release with side = 1 -> back_sel = 0.
